dcache_wb: RTL
==============

Name: dcache_wb

Overview:
Direct-mapped, write-back, write-allocate data cache between the pipeline's DCACHE_* port and the 128-bit-block main-memory interface. It serves one 32-bit word per request, with hit data returned combinationally in the request cycle. On a miss it holds the pipeline stalled while it evicts a dirty line (if any) and refills the missing line. No endian conversion is done here; the pipeline owns byte ordering.

Parameters:
INDEX_W, 3, index width; number of lines = 2**INDEX_W (8).
TAG_W, 25, tag width; must equal 28 - INDEX_W.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous, active-low reset.
proc_read  input  1  word read request (the pipeline's DCACHE_ren).
proc_write  input  1  word write request (the pipeline's DCACHE_wen).
proc_addr  input  30  word address: [1:0] word offset, [INDEX_W+1:2] index, [29:INDEX_W+2] tag.
proc_wdata  input  32  store data.
proc_stall  output  1  pipeline must hold the request and all pipeline state while this is 1.
proc_rdata  output  32  load data; valid when proc_read=1 and proc_stall=0.
mem_read  output  1  block refill request.
mem_write  output  1  block write-back request.
mem_addr  output  28  block address.
mem_wdata  output  128  write-back block.
mem_rdata  input  128  refill block.
mem_ready  input  1  one-cycle pulse: transfer done; rdata valid on a refill.

Behaviour:
- One clock; reset is asynchronous and active-low.
- Storage per line: valid, dirty, tag[TAG_W-1:0], data[127:0]. Word k of a block occupies data[32k+31:32k].
- Reset (at any time, including mid-transaction):
  - All valid and dirty bits are cleared and the state goes to IDLE.
  - mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0.
  - With no request present, proc_stall=0 and proc_rdata=0.
  - Line data is cleared to 0.
- req = proc_read | proc_write. If both are 1, the request is treated as a write.
- hit = valid[idx] & (tag[idx] == proc_addr tag field).
- proc_rdata always equals the word of line idx selected by the offset field.
- States:
  - IDLE:
    - proc_stall = req & ~hit.
    - Write hit: on the clock edge, the selected word is replaced with proc_wdata and dirty[idx] is set to 1. The other three words are unchanged. Zero-latency, no memory traffic.
    - Read hit: zero-latency, no state change.
    - Miss with valid[idx] & dirty[idx]: go to WRITEBACK.
    - Other miss: go to ALLOCATE.
    - No request: stay in IDLE.
  - WRITEBACK:
    - proc_stall=1, mem_write=1, mem_addr={tag[idx], idx}, mem_wdata=data[idx].
    - All three are held stable until mem_ready.
    - On mem_ready: go to ALLOCATE.
  - ALLOCATE:
    - proc_stall=1, mem_read=1, mem_addr=proc_addr[29:2], held stable.
    - On mem_ready: data[idx]=mem_rdata, tag updated, valid=1, dirty=0; go to IDLE.
    - The retried request then hits in IDLE. A retried write merges at that point and sets dirty.
- Miss latency: 1 cycle in IDLE, plus the memory wait(s), plus 1 hit cycle.
- mem_read and mem_write are never 1 at the same time. Both are 0 in IDLE.
- mem_ready received in IDLE is ignored.
- proc_addr and proc_wdata must not change while proc_stall=1. The cache indexes from live proc_addr in every state.

Test Plan:
1. Reset, then proc_read addr 0x00000001 -> proc_stall=1, mem_read=1, mem_addr=0x0000000. After 4 cycles, mem_ready with mem_rdata=128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA -> next cycle proc_stall=0, proc_rdata=0xBBBBBBBB.
2. After test 1, proc_write addr 0x00000003 data 0x12345678, then read the same address -> no stall either cycle, proc_rdata=0x12345678, no mem_read or mem_write.
3. Dirty eviction:
   - Stimulus: after test 2, proc_read addr 0x00000020 (tag 1, index 0).
   - Required: mem_write=1, mem_addr=0x0000000, mem_wdata=128'h12345678_CCCCCCCC_BBBBBBBB_AAAAAAAA.
   - Then, after mem_ready: mem_read=1, mem_addr=0x0000008.
   - After that mem_ready: the read hits.
4. Write miss to a clean line: proc_write addr 0x00000045 data 0xCAFEF00D -> refill mem_addr=0x0000011, then the merged word sits at bits [63:32] with dirty=1. A later eviction of that line writes back exactly that merged block.
5. mem_ready delayed 20 cycles in ALLOCATE -> proc_stall, mem_read and mem_addr held constant for every cycle. A spurious mem_ready in IDLE causes no state change.
6. rst_n dropped asynchronously mid-WRITEBACK -> mem_write=0 immediately, without waiting for a clock edge. After release, a read to a previously cached address misses.

Source files
------------

// File: rtl/dcache_wb.sv
// Direct-mapped, write-back, write-allocate data cache: one 32-bit word per request,
// 128-bit block refill/write-back towards main memory.
module dcache_wb #(
    parameter int unsigned INDEX_W = 3,
    parameter int unsigned TAG_W   = 25
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         proc_read,
    input  logic         proc_write,
    input  logic [29:0]  proc_addr,
    input  logic [31:0]  proc_wdata,
    output logic         proc_stall,
    output logic [31:0]  proc_rdata,
    output logic         mem_read,
    output logic         mem_write,
    output logic [27:0]  mem_addr,
    output logic [127:0] mem_wdata,
    input  logic [127:0] mem_rdata,
    input  logic         mem_ready
);

    localparam int unsigned LINES = 2 ** INDEX_W;

    typedef enum logic [1:0] {StIdle, StWriteback, StAllocate} state_e;

    state_e state_q, state_d;

    logic               valid_q [LINES];
    logic               dirty_q [LINES];
    logic [TAG_W-1:0]   tag_q   [LINES];
    logic [127:0]       data_q  [LINES];

    logic [INDEX_W-1:0] idx;
    logic [TAG_W-1:0]   tag;
    logic [1:0]         off;
    logic               req;
    logic               hit;
    logic               hit_wr;
    logic               refill;

    assign idx = proc_addr[INDEX_W+1:2];
    assign tag = proc_addr[29:INDEX_W+2];
    assign off = proc_addr[1:0];
    assign req = proc_read | proc_write;
    assign hit = valid_q[idx] & (tag_q[idx] == tag);

    assign proc_rdata = data_q[idx][{off, 5'b0} +: 32];

    always_comb begin
        state_d    = state_q;
        proc_stall = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        hit_wr     = 1'b0;
        refill     = 1'b0;
        case (state_q)
            StIdle: begin
                proc_stall = req & ~hit;
                // A simultaneous read+write is treated as a write.
                hit_wr     = proc_write & hit;
                if (req && !hit) begin
                    state_d = (valid_q[idx] && dirty_q[idx]) ? StWriteback : StAllocate;
                end
            end
            StWriteback: begin
                proc_stall = 1'b1;
                mem_write  = 1'b1;
                mem_addr   = {tag_q[idx], idx};
                mem_wdata  = data_q[idx];
                if (mem_ready) begin
                    state_d = StAllocate;
                end
            end
            StAllocate: begin
                proc_stall = 1'b1;
                mem_read   = 1'b1;
                mem_addr   = proc_addr[29:2];
                if (mem_ready) begin
                    refill  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            for (int i = 0; i < int'(LINES); i++) begin
                valid_q[i] <= 1'b0;
                dirty_q[i] <= 1'b0;
                tag_q[i]   <= '0;
                data_q[i]  <= '0;
            end
        end else begin
            state_q <= state_d;
            if (hit_wr) begin
                data_q[idx][{off, 5'b0} +: 32] <= proc_wdata;
                dirty_q[idx]                   <= 1'b1;
            end
            // The retried request merges on the following hit cycle, so refill leaves it clean.
            if (refill) begin
                data_q[idx]  <= mem_rdata;
                tag_q[idx]   <= tag;
                valid_q[idx] <= 1'b1;
                dirty_q[idx] <= 1'b0;
            end
        end
    end

endmodule
